// File: rtl/microsequencer_pkg.sv
// Shared definitions for the microsequencer: next-state op codes, condition
// selects and the microword field layout helpers.
package microsequencer_pkg;

  typedef enum logic [2:0] {
    NS_FETCH  = 3'b000,
    NS_INC    = 3'b001,
    NS_JUMP   = 3'b010,
    NS_DECODE = 3'b011,
    NS_CJUMP  = 3'b100,
    NS_WAIT   = 3'b101,
    NS_CALL   = 3'b110,
    NS_RET    = 3'b111
  } ns_op_e;

  typedef enum logic [1:0] {
    CSEL_MFC  = 2'b00,
    CSEL_COND = 2'b01,
    CSEL_IRB  = 2'b10,
    CSEL_ONE  = 2'b11
  } csel_e;

  localparam int unsigned NS_W   = 3;
  localparam int unsigned CSEL_W = 2;
  localparam int unsigned HDR_W  = NS_W + 1 + CSEL_W;

  // Microword, MSB->LSB: ns | inv | csel | pl | ctrl
  function automatic int unsigned word_width(input int unsigned state_w,
                                             input int unsigned ctrl_w);
    return ctrl_w + state_w + HDR_W;
  endfunction

  function automatic int unsigned pl_lsb(input int unsigned ctrl_w);
    return ctrl_w;
  endfunction

  function automatic int unsigned csel_lsb(input int unsigned state_w,
                                           input int unsigned ctrl_w);
    return ctrl_w + state_w;
  endfunction

  function automatic int unsigned inv_bit(input int unsigned state_w,
                                          input int unsigned ctrl_w);
    return ctrl_w + state_w + CSEL_W;
  endfunction

  function automatic int unsigned ns_lsb(input int unsigned state_w,
                                         input int unsigned ctrl_w);
    return ctrl_w + state_w + CSEL_W + 1;
  endfunction

  // Status bit: selected condition source, optionally inverted.
  function automatic logic status_bit(input csel_e csel, input logic inv,
                                      input logic mfc, input logic cond_true,
                                      input logic ir_bit);
    logic s;
    case (csel)
      CSEL_MFC:  s = mfc;
      CSEL_COND: s = cond_true;
      CSEL_IRB:  s = ir_bit;
      default:   s = 1'b1;
    endcase
    return s ^ inv;
  endfunction

endpackage

// File: rtl/microsequencer_ustack.sv
// Return-address stack: LIFO of DEPTH entries, W bits each, with an
// asynchronously reset occupancy count. Entry storage is not reset; only
// the count defines which entries are valid.
module ustack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     mem_q [2**AW];
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign top     = empty ? '0 : mem_q[AW'(count_q - CNT_W'(1))];

  // Next occupancy: push and pop are never requested together by the sequencer.
  always_comb begin
    count_d = count_q;
    if (do_push) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Occupancy register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Entry storage: write the slot just above the current top on push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[AW'(count_q)] <= din;
    end
  end

endmodule

// File: rtl/microsequencer.sv
// Microprogrammed sequencer: control store, condition mux/inverter,
// next-state selection, microstate register and call/return stack.
// The control store image is supplied as a flat parameter, word i at
// bits [i*WORD_W +: WORD_W], so the store is pure combinational ROM.
module microsequencer
  import microsequencer_pkg::*;
#(
  parameter int unsigned STATE_W     = 6,
  parameter int unsigned CTRL_W      = 32,
  parameter int unsigned STACK_DEPTH = 4,
  parameter logic [(2**STATE_W)*word_width(STATE_W, CTRL_W)-1:0] ROM_INIT = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic               mfc,
  input  logic               cond_true,
  input  logic               ir_bit,
  input  logic [STATE_W-1:0] decode_addr,
  output logic [CTRL_W-1:0]  ctrl,
  output logic [STATE_W-1:0] state,
  output logic               stack_err
);

  localparam int unsigned ROM_DEPTH = 2**STATE_W;
  localparam int unsigned WORD_W    = word_width(STATE_W, CTRL_W);
  localparam int unsigned PL_LSB    = pl_lsb(CTRL_W);
  localparam int unsigned CSEL_LSB  = csel_lsb(STATE_W, CTRL_W);
  localparam int unsigned INV_BIT   = inv_bit(STATE_W, CTRL_W);
  localparam int unsigned NS_LSB    = ns_lsb(STATE_W, CTRL_W);

  logic [STATE_W-1:0] state_q, state_d;
  logic               err_q, err_set;

  logic [WORD_W-1:0]  rom [ROM_DEPTH];
  logic [WORD_W-1:0]  word;
  ns_op_e             ns_op;
  csel_e              csel;
  logic               inv;
  logic [STATE_W-1:0] pl;
  logic [STATE_W-1:0] inc;
  logic               sts;

  logic               stk_push, stk_pop;
  logic [STATE_W-1:0] stk_top;
  logic               stk_full, stk_empty;

  for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_rom
    assign rom[g] = ROM_INIT[g*WORD_W +: WORD_W];
  end

  assign word  = rom[state_q];
  assign ns_op = ns_op_e'(word[NS_LSB +: NS_W]);
  assign inv   = word[INV_BIT];
  assign csel  = csel_e'(word[CSEL_LSB +: CSEL_W]);
  assign pl    = word[PL_LSB +: STATE_W];
  assign ctrl  = word[CTRL_W-1:0];

  assign inc       = state_q + STATE_W'(1);
  assign sts       = status_bit(csel, inv, mfc, cond_true, ir_bit);
  assign state     = state_q;
  assign stack_err = err_q;

  // Next-state selection and stack requests for the current microword.
  always_comb begin
    state_d  = state_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    err_set  = 1'b0;
    case (ns_op)
      NS_FETCH:  state_d = '0;
      NS_INC:    state_d = inc;
      NS_JUMP:   state_d = pl;
      NS_DECODE: state_d = decode_addr;
      NS_CJUMP:  state_d = sts ? pl : inc;
      NS_WAIT:   state_d = sts ? inc : state_q;
      NS_CALL: begin
        state_d = pl;
        if (stk_full) begin
          err_set = 1'b1;
        end else begin
          stk_push = clk_en;
        end
      end
      NS_RET: begin
        if (stk_empty) begin
          state_d = '0;
          err_set = 1'b1;
        end else begin
          state_d = stk_top;
          stk_pop = clk_en;
        end
      end
      default:   state_d = '0;
    endcase
  end

  // Microstate register and sticky stack error; both frozen while clk_en=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      err_q   <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  ustack #(
    .DEPTH (STACK_DEPTH),
    .W     (STATE_W)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (inc),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

endmodule

// File: tb/tb_microsequencer.sv
// Directed testbench for microsequencer with a hand-built microprogram.
module tb_microsequencer;
  import microsequencer_pkg::*;

  localparam int unsigned SW    = 6;
  localparam int unsigned CW    = 32;
  localparam int unsigned WW    = 44;
  localparam int unsigned DEPTH = 64;

  // Every word carries ctrl = C500_00xx with xx = its own address.
  function automatic logic [WW-1:0] mk(input logic [2:0] ns, input logic inv,
                                       input logic [1:0] csel, input logic [5:0] pl,
                                       input int unsigned a);
    logic [CW-1:0] c;
    c = 32'hC500_0000 | a;
    return {ns, inv, csel, pl, c};
  endfunction

  function automatic logic [DEPTH*WW-1:0] setw(input logic [DEPTH*WW-1:0] r,
                                               input int unsigned a, input logic [2:0] ns,
                                               input logic inv, input logic [1:0] csel,
                                               input logic [5:0] pl);
    logic [DEPTH*WW-1:0] o;
    o = r;
    o[a*WW +: WW] = mk(ns, inv, csel, pl, a);
    return o;
  endfunction

  function automatic logic [DEPTH*WW-1:0] build_rom();
    logic [DEPTH*WW-1:0] r;
    for (int i = 0; i < DEPTH; i++) r[i*WW +: WW] = mk(NS_FETCH, 1'b0, CSEL_MFC, 6'h00, i);
    r = setw(r, 'h00, NS_INC,    1'b0, CSEL_MFC,  6'h00);
    r = setw(r, 'h01, NS_WAIT,   1'b0, CSEL_MFC,  6'h00);
    r = setw(r, 'h02, NS_DECODE, 1'b0, CSEL_MFC,  6'h00);
    r = setw(r, 'h05, NS_WAIT,   1'b0, CSEL_MFC,  6'h00);
    r = setw(r, 'h08, NS_CALL,   1'b0, CSEL_MFC,  6'h30);
    r = setw(r, 'h0A, NS_CALL,   1'b0, CSEL_MFC,  6'h38);
    r = setw(r, 'h0C, NS_CALL,   1'b0, CSEL_MFC,  6'h0E);
    r = setw(r, 'h0E, NS_CALL,   1'b0, CSEL_MFC,  6'h05);
    r = setw(r, 'h10, NS_CJUMP,  1'b0, CSEL_COND, 6'h20);
    r = setw(r, 'h12, NS_CJUMP,  1'b0, CSEL_IRB,  6'h20);
    r = setw(r, 'h13, NS_JUMP,   1'b0, CSEL_MFC,  6'h2F);
    r = setw(r, 'h14, NS_CJUMP,  1'b1, CSEL_ONE,  6'h20);
    r = setw(r, 'h18, NS_CJUMP,  1'b1, CSEL_COND, 6'h20);
    r = setw(r, 'h21, NS_CALL,   1'b0, CSEL_MFC,  6'h23);
    r = setw(r, 'h22, NS_RET,    1'b0, CSEL_MFC,  6'h00);
    r = setw(r, 'h23, NS_CALL,   1'b0, CSEL_MFC,  6'h25);
    r = setw(r, 'h24, NS_RET,    1'b0, CSEL_MFC,  6'h00);
    r = setw(r, 'h25, NS_CALL,   1'b0, CSEL_MFC,  6'h27);
    r = setw(r, 'h26, NS_RET,    1'b0, CSEL_MFC,  6'h00);
    r = setw(r, 'h27, NS_CALL,   1'b0, CSEL_MFC,  6'h29);
    r = setw(r, 'h28, NS_RET,    1'b0, CSEL_MFC,  6'h00);
    r = setw(r, 'h29, NS_CALL,   1'b0, CSEL_MFC,  6'h2B);
    r = setw(r, 'h2B, NS_RET,    1'b0, CSEL_MFC,  6'h00);
    r = setw(r, 'h30, NS_RET,    1'b0, CSEL_MFC,  6'h00);
    r = setw(r, 'h38, NS_CALL,   1'b0, CSEL_MFC,  6'h3A);
    r = setw(r, 'h39, NS_RET,    1'b0, CSEL_MFC,  6'h00);
    r = setw(r, 'h3A, NS_CALL,   1'b0, CSEL_MFC,  6'h3C);
    r = setw(r, 'h3B, NS_RET,    1'b0, CSEL_MFC,  6'h00);
    r = setw(r, 'h3C, NS_CALL,   1'b0, CSEL_MFC,  6'h3E);
    r = setw(r, 'h3D, NS_RET,    1'b0, CSEL_MFC,  6'h00);
    r = setw(r, 'h3E, NS_RET,    1'b0, CSEL_MFC,  6'h00);
    r = setw(r, 'h3F, NS_INC,    1'b0, CSEL_MFC,  6'h00);
    return r;
  endfunction

  localparam logic [DEPTH*WW-1:0] ROM = build_rom();

  logic          clk, rst, clk_en, mfc, cond_true, ir_bit;
  logic [SW-1:0] decode_addr;
  logic [CW-1:0] ctrl;
  logic [SW-1:0] state;
  logic          stack_err;

  int n_tests = 0;
  int n_fail  = 0;

  microsequencer #(
    .STATE_W     (SW),
    .CTRL_W      (CW),
    .STACK_DEPTH (4),
    .ROM_INIT    (ROM)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .mfc         (mfc),
    .cond_true   (cond_true),
    .ir_bit      (ir_bit),
    .decode_addr (decode_addr),
    .ctrl        (ctrl),
    .state       (state),
    .stack_err   (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; clk_en = 1'b1; mfc = 1'b0; cond_true = 1'b0; ir_bit = 1'b0; decode_addr = '0;
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reset, then 0 (INC) -> 1 (WAIT, mfc=1) -> 2 (DECODE) -> a
  task automatic goto(input logic [SW-1:0] a);
    reset_dut();
    mfc = 1'b1; decode_addr = a;
    step(); step(); step();
    mfc = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    n_tests++; if (state !== 6'h00) begin n_fail++; $display("FAIL rst_state: got %h want 00", state); end
    n_tests++; if (ctrl !== 32'hC500_0000) begin n_fail++; $display("FAIL rst_ctrl: got %h want c5000000", ctrl); end
    n_tests++; if (stack_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", stack_err); end
    // Two calls (0C -> 0E -> 05), then hold in WAIT at 05
    goto(6'h0C);
    step(); step(); step();
    n_tests++; if (state !== 6'h05) begin n_fail++; $display("FAIL pre_rst_state: got %h want 05", state); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (state !== 6'h00) begin n_fail++; $display("FAIL async_rst_state: got %h want 00", state); end
    n_tests++; if (ctrl !== 32'hC500_0000) begin n_fail++; $display("FAIL async_rst_ctrl: got %h want c5000000", ctrl); end
    n_tests++; if (stack_err !== 1'b0) begin n_fail++; $display("FAIL async_rst_err: got %b want 0", stack_err); end
    @(negedge clk);
    rst = 1'b0;
    // Stack must be empty now: RET at 22 underflows to 0
    mfc = 1'b1; decode_addr = 6'h22;
    step(); step(); step();
    mfc = 1'b0;
    step();
    n_tests++; if (state !== 6'h00) begin n_fail++; $display("FAIL rst_stack_empty: got %h want 00", state); end
    n_tests++; if (stack_err !== 1'b1) begin n_fail++; $display("FAIL rst_stack_uflow_err: got %b want 1", stack_err); end
  endtask

  task automatic test_wait();
    reset_dut();
    step();
    n_tests++; if (state !== 6'h01) begin n_fail++; $display("FAIL wait_enter: got %h want 01", state); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (state !== 6'h01) begin n_fail++; $display("FAIL wait_hold%0d: got %h want 01", i, state); end
      n_tests++; if (ctrl !== 32'hC500_0001) begin n_fail++; $display("FAIL wait_ctrl%0d: got %h want c5000001", i, ctrl); end
    end
    mfc = 1'b1;
    step();
    n_tests++; if (state !== 6'h02) begin n_fail++; $display("FAIL wait_release: got %h want 02", state); end
  endtask

  task automatic test_decode_cjump();
    goto(6'h10);
    n_tests++; if (state !== 6'h10) begin n_fail++; $display("FAIL decode: got %h want 10", state); end
    n_tests++; if (ctrl !== 32'hC500_0010) begin n_fail++; $display("FAIL decode_ctrl: got %h want c5000010", ctrl); end
    cond_true = 1'b0; step();
    n_tests++; if (state !== 6'h11) begin n_fail++; $display("FAIL cjump_false: got %h want 11", state); end
    goto(6'h10); cond_true = 1'b1; step();
    n_tests++; if (state !== 6'h20) begin n_fail++; $display("FAIL cjump_true: got %h want 20", state); end
    goto(6'h18); cond_true = 1'b1; step();
    n_tests++; if (state !== 6'h19) begin n_fail++; $display("FAIL cjump_inv_true: got %h want 19", state); end
    goto(6'h18); cond_true = 1'b0; step();
    n_tests++; if (state !== 6'h20) begin n_fail++; $display("FAIL cjump_inv_false: got %h want 20", state); end
    goto(6'h12); ir_bit = 1'b1; step();
    n_tests++; if (state !== 6'h20) begin n_fail++; $display("FAIL cjump_irb1: got %h want 20", state); end
    goto(6'h12); ir_bit = 1'b0; step();
    n_tests++; if (state !== 6'h13) begin n_fail++; $display("FAIL cjump_irb0: got %h want 13", state); end
    step();
    n_tests++; if (state !== 6'h2F) begin n_fail++; $display("FAIL jump: got %h want 2f", state); end
    goto(6'h14); step();
    n_tests++; if (state !== 6'h15) begin n_fail++; $display("FAIL cjump_one_inv: got %h want 15", state); end
  endtask

  task automatic test_call_ret();
    logic [SW-1:0] exp_ret [4];
    goto(6'h08); step();
    n_tests++; if (state !== 6'h30) begin n_fail++; $display("FAIL call: got %h want 30", state); end
    step();
    n_tests++; if (state !== 6'h09) begin n_fail++; $display("FAIL ret: got %h want 09", state); end
    n_tests++; if (stack_err !== 1'b0) begin n_fail++; $display("FAIL call_ret_err: got %b want 0", stack_err); end
    // Four nested calls: 0A -> 38 -> 3A -> 3C -> 3E
    goto(6'h0A);
    step(); step(); step(); step();
    n_tests++; if (state !== 6'h3E) begin n_fail++; $display("FAIL nest_depth4: got %h want 3e", state); end
    exp_ret = '{6'h3D, 6'h3B, 6'h39, 6'h0B};
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++; if (state !== exp_ret[i]) begin n_fail++; $display("FAIL nest_ret%0d: got %h want %h", i, state, exp_ret[i]); end
    end
    n_tests++; if (stack_err !== 1'b0) begin n_fail++; $display("FAIL nest_err: got %b want 0", stack_err); end
  endtask

  task automatic test_overflow();
    logic [SW-1:0] exp_ret [4];
    goto(6'h21);
    step(); step(); step(); step();
    n_tests++; if (state !== 6'h29) begin n_fail++; $display("FAIL ovf_fill: got %h want 29", state); end
    n_tests++; if (stack_err !== 1'b0) begin n_fail++; $display("FAIL ovf_err_before: got %b want 0", stack_err); end
    step();
    n_tests++; if (state !== 6'h2B) begin n_fail++; $display("FAIL ovf_jump: got %h want 2b", state); end
    n_tests++; if (stack_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b want 1", stack_err); end
    exp_ret = '{6'h28, 6'h26, 6'h24, 6'h22};
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++; if (state !== exp_ret[i]) begin n_fail++; $display("FAIL ovf_ret%0d: got %h want %h", i, state, exp_ret[i]); end
    end
    step();
    n_tests++; if (state !== 6'h00) begin n_fail++; $display("FAIL uflow_state: got %h want 00", state); end
    step();
    n_tests++; if (stack_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", stack_err); end
    reset_dut();
    n_tests++; if (stack_err !== 1'b0) begin n_fail++; $display("FAIL err_clear_rst: got %b want 0", stack_err); end
  endtask

  task automatic test_clk_en();
    goto(6'h3F);
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (state !== 6'h3F) begin n_fail++; $display("FAIL hold%0d: got %h want 3f", i, state); end
      n_tests++; if (ctrl !== 32'hC500_003F) begin n_fail++; $display("FAIL hold_ctrl%0d: got %h want c500003f", i, ctrl); end
    end
    clk_en = 1'b1; step();
    n_tests++; if (state !== 6'h00) begin n_fail++; $display("FAIL wrap: got %h want 00", state); end
    // Stack is frozen too: RET while disabled must not pop
    goto(6'h08); step();
    clk_en = 1'b0; step(); step();
    n_tests++; if (state !== 6'h30) begin n_fail++; $display("FAIL hold_ret: got %h want 30", state); end
    clk_en = 1'b1; step();
    n_tests++; if (state !== 6'h09) begin n_fail++; $display("FAIL ret_after_hold: got %h want 09", state); end
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; mfc = 1'b0; cond_true = 1'b0; ir_bit = 1'b0; decode_addr = '0;
    test_reset();
    test_wait();
    test_decode_cjump();
    test_call_ret();
    test_overflow();
    test_clk_en();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
